// File: rtl/approx_mult_pkg.sv
// Shared types and default widths for the approximate-multiplier accumulator slice.
package approx_mult_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned DEF_PROD_W = 16;
   localparam int unsigned DEF_ACC_W  = 24;
   localparam int unsigned DEF_LEN_W  = 8;

endpackage

// File: rtl/acc_sat_add.sv
// Combinational ACC_W adder with carry out; clamps to all-ones on carry when SATURATE_EN is defined.
module acc_sat_add
   import approx_mult_pkg::*;
#(
   parameter int unsigned ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] prod,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W-1:0] raw_sum;

   assign {carry, raw_sum} = {1'b0, acc} + {1'b0, prod};

`ifdef SATURATE_EN
   // Once clamped, any further non-zero product carries again, so the sum stays pinned.
   assign sum = carry ? '1 : raw_sum;
`else
   assign sum = raw_sum;
`endif

endmodule

// File: rtl/approx_mult_accumulator.sv
// Frame accumulator for approximate-multiplier products; SATURATE_EN selects clamping over wrap.
module approx_mult_accumulator
   import approx_mult_pkg::*;
#(
   parameter int unsigned PROD_W = DEF_PROD_W,
   parameter int unsigned ACC_W  = DEF_ACC_W,
   parameter int unsigned LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_Y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf,
   output logic              busy
);

   if (ACC_W < PROD_W) begin : g_bad_width
      $error("approx_mult_accumulator: ACC_W must be >= PROD_W");
   end

   state_t             state_q, state_n;
   logic [ACC_W-1:0]   acc_q;
   logic [LEN_W-1:0]   cnt_q;
   logic               ovf_q;
   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W-1:0]   sum_n;
   logic               carry_n;
   logic               beat;

   always_comb begin
      prod_ext = '0;
      prod_ext[PROD_W-1:0] = in_Y;
   end

   acc_sat_add #(.ACC_W(ACC_W)) u_add (
      .acc   (acc_q),
      .prod  (prod_ext),
      .sum   (sum_n),
      .carry (carry_n)
   );

   assign beat = in_valid && (state_q == ACCUM);

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (start) state_n = (len != '0) ? ACCUM : DONE;
         ACCUM:   if (beat && (cnt_q == LEN_W'(1))) state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         if (state_q == IDLE && start) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= len;
         end else if (beat) begin
            acc_q <= sum_n;
            cnt_q <= cnt_q - LEN_W'(1);
            if (carry_n) ovf_q <= 1'b1;
         end
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_approx_mult_accumulator.sv
// Directed bench: default-width DUT plus an ACC_W=16 DUT for overflow behaviour.
module tb_approx_mult_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [15:0] in_Y;
   logic        out_ready;

   logic        in_ready0, out_valid0, out_ovf0, busy0;
   logic [23:0] out_sum0;
   logic        in_ready1, out_valid1, out_ovf1, busy1;
   logic [15:0] out_sum1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   approx_mult_accumulator dut0 (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready0), .in_Y(in_Y),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_sum(out_sum0), .out_ovf(out_ovf0), .busy(busy0)
   );

   approx_mult_accumulator #(.ACC_W(16)) dut1 (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready1), .in_Y(in_Y),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_sum(out_sum1), .out_ovf(out_ovf1), .busy(busy1)
   );

   typedef struct {
      logic [7:0]        len;
      logic [3:0][15:0]  y;
      logic [23:0]       exp_sum;
      logic              exp_ovf;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input string name, input logic [7:0] l,
                            input logic [3:0][15:0] y,
                            input logic [23:0] exp_sum, input logic exp_ovf);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
      for (int unsigned i = 0; i < l; i++) begin
         chk({name, " in_ready"}, {31'd0, in_ready0}, 32'd1);
         chk({name, " no early valid"}, {31'd0, out_valid0}, 32'd0);
         in_valid = 1'b1;
         in_Y     = y[i];
         tick();
      end
      in_valid = 1'b0;
      chk({name, " out_valid"}, {31'd0, out_valid0}, 32'd1);
      chk({name, " sum"}, {8'd0, out_sum0}, {8'd0, exp_sum});
      chk({name, " ovf"}, {31'd0, out_ovf0}, {31'd0, exp_ovf});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({name, " idle after"}, {31'd0, busy0}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_Y = '0; out_ready = 1'b0;
      vecs[0] = '{len: 8'd4, y: {16'd400, 16'd300, 16'd200, 16'd100}, exp_sum: 24'd1000,    exp_ovf: 1'b0};
      vecs[1] = '{len: 8'd1, y: {16'd0, 16'd0, 16'd0, 16'hFFFF},        exp_sum: 24'h00FFFF,  exp_ovf: 1'b0};
      vecs[2] = '{len: 8'd3, y: {16'd0, 16'd9, 16'd8, 16'd7},          exp_sum: 24'd24,      exp_ovf: 1'b0};
      vecs[3] = '{len: 8'd0, y: {16'd1, 16'd1, 16'd1, 16'd1},          exp_sum: 24'd0,       exp_ovf: 1'b0};
      vecs[4] = '{len: 8'd4, y: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, exp_sum: 24'h03FFFC, exp_ovf: 1'b0};

      tick(); tick();
      chk("reset out_valid", {31'd0, out_valid0}, 32'd0);
      chk("reset in_ready",  {31'd0, in_ready0},  32'd0);
      chk("reset busy",      {31'd0, busy0},      32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].y,
                                            vecs[i].exp_sum, vecs[i].exp_ovf);
      tick();

      // Gapped input, back-pressured output
      start = 1'b1; len = 8'd3; tick(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_Y = 16'(7 + i); tick();
         in_valid = 1'b0;
         if (i < 2) begin
            tick(); tick();
            chk("gap in_ready", {31'd0, in_ready0}, 32'd1);
            chk("gap no valid", {31'd0, out_valid0}, 32'd0);
         end
      end
      in_valid = 1'b1; in_Y = 16'd50;
      for (int i = 0; i < 3; i++) begin
         chk("hold valid",    {31'd0, out_valid0}, 32'd1);
         chk("hold sum",      {8'd0, out_sum0}, 32'd24);
         chk("hold in_ready", {31'd0, in_ready0}, 32'd0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("gap idle", {31'd0, busy0}, 32'd0);

      // Carry out of a 16-bit accumulator
      start = 1'b1; len = 8'd2; tick(); start = 1'b0;
      in_valid = 1'b1; in_Y = 16'hFFFF; tick();
      in_Y = 16'h0002; tick();
      in_valid = 1'b0;
      chk("ovf16 valid", {31'd0, out_valid1}, 32'd1);
`ifdef SATURATE_EN
      chk("ovf16 sum", {16'd0, out_sum1}, 32'h0000FFFF);
`else
      chk("ovf16 sum", {16'd0, out_sum1}, 32'h00000001);
`endif
      chk("ovf16 ovf",  {31'd0, out_ovf1}, 32'd1);
      chk("ovf24 sum",  {8'd0, out_sum0}, 32'h00010001);
      chk("ovf24 ovf",  {31'd0, out_ovf0}, 32'd0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      // Zero-length frame; start pulses in DONE are ignored
      start = 1'b1; len = 8'd0; tick();
      chk("len0 valid", {31'd0, out_valid0}, 32'd1);
      chk("len0 sum",   {8'd0, out_sum0}, 32'd0);
      chk("len0 ovf16 cleared", {31'd0, out_ovf1}, 32'd0);
      len = 8'd3; tick();
      chk("start in DONE held", {31'd0, out_valid0}, 32'd1);
      out_ready = 1'b1; tick();
      chk("start in DONE w/ready -> idle", {31'd0, busy0}, 32'd0);
      start = 1'b0; out_ready = 1'b0; tick();
      chk("start not re-taken", {31'd0, busy0}, 32'd0);

      // Reset mid-frame, then a fresh frame
      start = 1'b1; len = 8'd4; tick(); start = 1'b0;
      in_valid = 1'b1; in_Y = 16'd50; tick(); in_Y = 16'd60; tick();
      in_valid = 1'b0;
      rst = 1'b1; #1;
      chk("midrst valid",    {31'd0, out_valid0}, 32'd0);
      chk("midrst in_ready", {31'd0, in_ready0},  32'd0);
      chk("midrst busy",     {31'd0, busy0},      32'd0);
      chk("midrst sum",      {8'd0, out_sum0},    32'd0);
      chk("midrst ovf",      {31'd0, out_ovf0},   32'd0);
      tick(); rst = 1'b0; tick(); tick();
      chk("post rst no valid", {31'd0, out_valid0}, 32'd0);
      run_frame("after rst", 8'd2, {16'd0, 16'd0, 16'd6, 16'd5}, 24'd11, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
